// File: rtl/approx_mul_trunc_pipe.sv
// approx_mul_trunc_pipe: low-row truncated approximate multiplier on a valid/ready pipeline.
// Define APPROX_MUL_ERR_STAT_EN to add |exact - z| error statistics ports.
module approx_mul_trunc_pipe #(
  parameter int N      = 8,
  parameter int L      = 4,
  parameter int C      = 7,
  parameter int COMP   = 0,
  parameter int STAGES = 2,
  parameter int ERR_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z
`ifdef APPROX_MUL_ERR_STAT_EN
  ,
  input  logic             stat_clr,
  output logic [ERR_W-1:0] err_sum,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam int W  = 2 * N;
  localparam int CB = (C > 0) ? C - 1 : 0;

  logic [W-1:0] yw;
  logic [W-1:0] h;
  logic [W-1:0] p;
  logic [W-1:0] lo;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] zc;
  logic         stall;

  logic [STAGES-1:0] v_q;
  logic [W-1:0]      d_q [STAGES];

  assign yw = W'(y);

  // Approximated rows: partial products of x[L-1:0] at full width.
  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (i < L && x[i]) begin
        p = p + (yw << i);
      end
    end
  end

  assign h  = (yw * W'(x >> L)) << L;
  assign lo = p & ~({W{1'b1}} << C);
  assign a  = p & ({W{1'b1}} << C);
  assign b  = (COMP != 0 && C > 0 && lo != '0) ? (W'(1) << CB) : '0;
  assign zc = h + a + b;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v_q[STAGES-1];
  assign z         = out_valid ? d_q[STAGES-1] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        d_q[s] <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= in_valid;
      d_q[0] <= zc;
      for (int s = 1; s < STAGES; s++) begin
        v_q[s] <= v_q[s-1];
        d_q[s] <= d_q[s-1];
      end
    end
  end

`ifdef APPROX_MUL_ERR_STAT_EN
  localparam int SW = ((ERR_W > W) ? ERR_W : W) + 1;
  localparam logic [ERR_W-1:0] EMAX = '1;

  logic [W-1:0]     e_q [STAGES];
  logic [W-1:0]     e_out;
  logic [W-1:0]     diff;
  logic [SW-1:0]    sum_w;
  logic [ERR_W-1:0] sum_n;
  logic [ERR_W-1:0] cnt_n;

  // Exact product rides alongside z; its data is don't-care when invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        e_q[s] <= '0;
      end
    end else if (!stall) begin
      e_q[0] <= W'(x) * yw;
      for (int s = 1; s < STAGES; s++) begin
        e_q[s] <= e_q[s-1];
      end
    end
  end

  assign e_out = e_q[STAGES-1];
  assign diff  = (e_out >= z) ? e_out - z : z - e_out;
  assign sum_w = SW'(err_sum) + SW'(diff);
  assign sum_n = (sum_w > SW'(EMAX)) ? EMAX : sum_w[ERR_W-1:0];
  assign cnt_n = (err_cnt == EMAX) ? EMAX : err_cnt + ERR_W'(1);

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      err_sum <= '0;
      err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      err_sum <= sum_n;
      err_cnt <= cnt_n;
    end
  end
`endif

endmodule
